// File: rtl/apb_master_engine.sv
// apb_master_engine
//   Expands one AXI-style burst command into a sequence of single APB3
//   transfers (SETUP -> ACCESS per beat). Write beats are popped from the
//   write-data queue one at a time, read beats are returned with per-beat
//   resp/last, and a write burst finishes with a single accumulated response.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_*                 burst command handshake (write, addr, len, size, burst)
//   wd_*                  write-data queue pop interface
//   rd_*                  read beat return (data, resp, last)
//   done_*                write burst response
//   p*                    APB3 master signals
module apb_master_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_BIT    = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [3:0]            cmd_len_i,
    input  logic [2:0]            cmd_size_i,
    input  logic [1:0]            cmd_burst_i,
    input  logic                  wd_valid_i,
    input  logic [DATA_WIDTH-1:0] wd_data_i,
    output logic                  wd_ready_o,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [1:0]            rd_resp_o,
    output logic                  rd_last_o,
    input  logic                  rd_ready_i,
    output logic                  done_valid_o,
    output logic [1:0]            done_resp_o,
    input  logic                  done_ready_i,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic                  pwrite_o,
    output logic                  penable_o,
    output logic [1:0]            psel_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_RDATA, S_DONE
    } state_t;

    state_t                state_q,   state_d;
    logic [ADDR_WIDTH-1:0] paddr_q,   paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,  pwdata_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_err_q,  rd_err_d;
    logic                  write_q,   write_d;
    logic [3:0]            len_q,     len_d;
    logic [3:0]            beat_q,    beat_d;
    logic [2:0]            size_q,    size_d;
    logic [1:0]            burst_q,   burst_d;
    logic                  err_q,     err_d;

    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  wrap_ok;
    logic                  last_beat;

    // Next beat address. WRAP keeps the bits above the wrap window and
    // lets only the bits inside it increment; non power-of-two WRAP lengths
    // fall back to INCR.
    always_comb begin
        inc       = ADDR_WIDTH'(1) << size_q;
        wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
        addr_inc  = paddr_q + inc;
        wrap_ok   = (burst_q == 2'b10) &&
                    ((len_q == 4'd1) || (len_q == 4'd3) || (len_q == 4'd7) || (len_q == 4'd15));
        if (burst_q == 2'b00) begin
            addr_next = paddr_q;
        end else if (wrap_ok) begin
            addr_next = (paddr_q & ~wrap_mask) | (addr_inc & wrap_mask);
        end else begin
            addr_next = addr_inc;
        end
        last_beat = (beat_q == len_q);
    end

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rd_data_d = rd_data_q;
        rd_err_d  = rd_err_q;
        write_d   = write_q;
        len_d     = len_q;
        beat_d    = beat_q;
        size_d    = size_q;
        burst_d   = burst_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    paddr_d = cmd_addr_i;
                    write_d = cmd_write_i;
                    len_d   = cmd_len_i;
                    size_d  = cmd_size_i;
                    burst_d = cmd_burst_i;
                    beat_d  = 4'd0;
                    err_d   = 1'b0;
                    state_d = cmd_write_i ? S_WDATA : S_SETUP;
                end
            end
            S_WDATA: begin
                if (wd_valid_i) begin
                    pwdata_d = wd_data_i;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (pready_i) begin
                    err_d = err_q | pslverr_i;
                    if (!write_q) begin
                        rd_data_d = prdata_i;
                        rd_err_d  = pslverr_i;
                        state_d   = S_RDATA;
                    end else if (last_beat) begin
                        state_d = S_DONE;
                    end else begin
                        paddr_d = addr_next;
                        beat_d  = beat_q + 4'd1;
                        state_d = S_WDATA;
                    end
                end
            end
            S_RDATA: begin
                if (rd_ready_i) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        paddr_d = addr_next;
                        beat_d  = beat_q + 4'd1;
                        state_d = S_SETUP;
                    end
                end
            end
            S_DONE: begin
                if (done_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
            write_q   <= 1'b0;
            len_q     <= 4'd0;
            beat_q    <= 4'd0;
            size_q    <= 3'd0;
            burst_q   <= 2'b00;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rd_data_q <= rd_data_d;
            rd_err_q  <= rd_err_d;
            write_q   <= write_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
        end
    end

    // All outputs are decoded straight from registered state, so an
    // asynchronous reset drops psel/penable in the same cycle. cmd_ready is
    // additionally gated by rst_n because the reset state itself is IDLE.
    assign cmd_ready_o  = rst_n && (state_q == S_IDLE);
    assign wd_ready_o   = (state_q == S_WDATA);
    assign psel_o       = ((state_q == S_SETUP) || (state_q == S_ACCESS)) ?
                          (paddr_q[SEL_BIT] ? 2'b10 : 2'b01) : 2'b00;
    assign penable_o    = (state_q == S_ACCESS);
    assign paddr_o      = paddr_q;
    assign pwdata_o     = pwdata_q;
    assign pwrite_o     = write_q;
    assign rd_valid_o   = (state_q == S_RDATA);
    assign rd_last_o    = (state_q == S_RDATA) && last_beat;
    assign rd_data_o    = rd_data_q;
    assign rd_resp_o    = {rd_err_q, 1'b0};
    assign done_valid_o = (state_q == S_DONE);
    assign done_resp_o  = {err_q, 1'b0};

endmodule

// File: tb/tb_apb_master_engine.sv
// tb_apb_master_engine
//   Directed bench for apb_master_engine: an APB slave model with
//   programmable wait states and a single error address, write-data and
//   read-beat drivers with programmable gaps/stalls, and a negedge monitor
//   that logs completed APB transfers, read beats and write responses.
module tb_apb_master_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [31:0] cmd_addr_i;
    logic [3:0]  cmd_len_i;
    logic [2:0]  cmd_size_i;
    logic [1:0]  cmd_burst_i;
    logic        wd_valid_i, wd_ready_o;
    logic [31:0] wd_data_i;
    logic        rd_valid_o, rd_last_o, rd_ready_i;
    logic [31:0] rd_data_o;
    logic [1:0]  rd_resp_o;
    logic        done_valid_o, done_ready_i;
    logic [1:0]  done_resp_o;
    logic [31:0] paddr_o, pwdata_o, prdata_i;
    logic        pwrite_o, penable_o, pready_i, pslverr_i;
    logic [1:0]  psel_o;

    always #5 clk = ~clk;

    apb_master_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_BIT(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_size_i(cmd_size_i),
        .cmd_burst_i(cmd_burst_i),
        .wd_valid_i(wd_valid_i), .wd_data_i(wd_data_i), .wd_ready_o(wd_ready_o),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_resp_o(rd_resp_o),
        .rd_last_o(rd_last_o), .rd_ready_i(rd_ready_i),
        .done_valid_o(done_valid_o), .done_resp_o(done_resp_o), .done_ready_i(done_ready_i),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o),
        .penable_o(penable_o), .psel_o(psel_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // APB slave model: read data is a fixed function of the address.
    int          pready_dly = 0;
    int          acc_cnt = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    assign pready_i  = (psel_o != 2'b00) && penable_o && (acc_cnt >= pready_dly);
    assign pslverr_i = pready_i && (paddr_o == err_addr);
    assign prdata_i  = paddr_o ^ 32'hC0DE_0000;
    always @(posedge clk) acc_cnt <= ((psel_o != 2'b00) && penable_o && !pready_i) ? acc_cnt + 1 : 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] ap_addr[$];
    logic [31:0] ap_wdata[$];
    logic        ap_wr[$];
    logic [1:0]  ap_sel[$];
    logic [31:0] rq_data[$];
    logic [1:0]  rq_resp[$];
    logic        rq_last[$];
    logic [1:0]  dq_resp[$];
    int          hs_cyc = 0;
    int          first_rd_cyc = -1;
    int          stab_bad = 0;
    int          proto_bad = 0;
    logic        wd_fire = 1'b0;
    logic        rd_fire = 1'b0;
    logic [31:0] s_addr, s_wdata, h_data;
    logic [1:0]  s_sel, h_resp;
    logic        s_wr, h_last;
    logic        rd_hold = 1'b0;

    always @(negedge clk) begin
        wd_fire = wd_valid_i && wd_ready_o;
        rd_fire = rd_valid_o && rd_ready_i;
        if (psel_o == 2'b11 || (penable_o && psel_o == 2'b00)) proto_bad++;
        if (psel_o != 2'b00 && !penable_o) begin
            s_addr = paddr_o; s_wdata = pwdata_o; s_sel = psel_o; s_wr = pwrite_o;
        end
        if (psel_o != 2'b00 && penable_o) begin
            if (paddr_o !== s_addr || pwdata_o !== s_wdata || psel_o !== s_sel || pwrite_o !== s_wr)
                stab_bad++;
            if (pready_i) begin
                ap_addr.push_back(paddr_o); ap_wdata.push_back(pwdata_o);
                ap_wr.push_back(pwrite_o);  ap_sel.push_back(psel_o);
            end
        end
        if (rd_valid_o) begin
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            if (rd_hold && (rd_data_o !== h_data || rd_resp_o !== h_resp || rd_last_o !== h_last))
                stab_bad++;
        end
        rd_hold = rd_valid_o && !rd_ready_i;
        h_data = rd_data_o; h_resp = rd_resp_o; h_last = rd_last_o;
        if (rd_fire) begin
            rq_data.push_back(rd_data_o); rq_resp.push_back(rd_resp_o); rq_last.push_back(rd_last_o);
        end
        if (done_valid_o && done_ready_i) dq_resp.push_back(done_resp_o);
        if (cmd_valid_i && cmd_ready_o) hs_cyc = cyc;
    end

    // Write-data source with a programmable idle gap before each beat.
    logic [31:0] wq[$];
    int          wd_gap = 0;
    int          wgap_cnt = 0;
    initial begin
        wd_valid_i = 1'b0;
        wd_data_i  = '0;
        forever begin
            @(posedge clk); #1;
            if (wd_fire) begin
                void'(wq.pop_front());
                wd_valid_i = 1'b0;
                wgap_cnt   = 0;
            end
            if (!wd_valid_i && wq.size() > 0) begin
                if (wgap_cnt >= wd_gap) begin
                    wd_valid_i = 1'b1;
                    wd_data_i  = wq[0];
                end else begin
                    wgap_cnt++;
                end
            end
        end
    end

    // Read-beat sink: rd_ready held low for rd_stall cycles of each beat.
    int rd_stall = 0;
    int rcnt = 0;
    initial begin
        rd_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rd_stall == 0) begin
                rd_ready_i = 1'b1;
            end else if (rd_fire || !rd_valid_o) begin
                rd_ready_i = 1'b0;
                rcnt = 0;
            end else if (!rd_ready_i) begin
                rcnt++;
                if (rcnt > rd_stall) rd_ready_i = 1'b1;
            end
        end
    end

    task automatic clear_logs();
        ap_addr.delete(); ap_wdata.delete(); ap_wr.delete(); ap_sel.delete();
        rq_data.delete(); rq_resp.delete(); rq_last.delete(); dq_resp.delete();
        first_rd_cyc = -1;
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [3:0] l,
                            input logic [2:0] s, input logic [1:0] b);
        int t;
        @(posedge clk); #1;
        cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = a;
        cmd_len_i = l; cmd_size_i = s; cmd_burst_i = b;
        t = 0;
        do begin @(negedge clk); t++; end while (!cmd_ready_o && t < 200);
        if (!cmd_ready_o) chk("cmd_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin @(negedge clk); t++; end while (!cmd_ready_o && t < 500);
        if (!cmd_ready_o) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // Compare the logged APB address sequence (up to four beats).
    task automatic chk_apb(input string tag, input int n, input logic [31:0] a0,
                           input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] a3);
        logic [31:0] e[4];
        e = '{a0, a1, a2, a3};
        chk($sformatf("%s_nxfer", tag), 32'(ap_addr.size()), 32'(n));
        for (int i = 0; i < n; i++)
            if (i < ap_addr.size()) chk($sformatf("%s_addr%0d", tag, i), ap_addr[i], e[i]);
    endtask

    // Compare logged read beats against the slave model for addresses in ap_addr.
    task automatic chk_rd(input string tag, input int n);
        chk($sformatf("%s_nrd", tag), 32'(rq_data.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < rq_data.size() && i < ap_addr.size()) begin
                chk($sformatf("%s_data%0d", tag, i), rq_data[i], ap_addr[i] ^ 32'hC0DE_0000);
                chk($sformatf("%s_last%0d", tag, i), 32'(rq_last[i]), 32'(i == n - 1));
            end
        end
    endtask

    initial begin
        cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0;
        cmd_len_i = '0; cmd_size_i = '0; cmd_burst_i = '0;
        done_ready_i = 1'b1;

        // reset state
        #12;
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
        chk("rst_psel", 32'(psel_o), 32'd0);
        chk("rst_penable", 32'(penable_o), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid_o), 32'd0);
        chk("rst_wd_ready", 32'(wd_ready_o), 32'd0);
        chk("rst_done_valid", 32'(done_valid_o), 32'd0);
        chk("rst_paddr", paddr_o, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", 32'(cmd_ready_o), 32'd1);

        // 1: read INCR, latency and last flag
        clear_logs();
        send_cmd(1'b0, 32'h100, 4'd3, 3'd2, 2'b01);
        wait_idle();
        chk_apb("t1", 4, 32'h100, 32'h104, 32'h108, 32'h10C);
        chk_rd("t1", 4);
        chk("t1_latency", 32'(first_rd_cyc - hs_cyc), 32'd3);
        if (ap_sel.size() > 0) chk("t1_psel", 32'(ap_sel[0]), 32'd1);
        if (ap_wr.size() > 0) chk("t1_pwrite", 32'(ap_wr[0]), 32'd0);
        if (rq_resp.size() > 0) chk("t1_resp", 32'(rq_resp[0]), 32'd0);

        // 2: write FIXED to the upper slave
        clear_logs();
        wq.push_back(32'hA5A5_A5A5); wq.push_back(32'h5A5A_5A5A);
        send_cmd(1'b1, 32'h1F00, 4'd1, 3'd2, 2'b00);
        wait_idle();
        chk_apb("t2", 2, 32'h1F00, 32'h1F00, 32'h0, 32'h0);
        if (ap_wdata.size() == 2) begin
            chk("t2_wdata0", ap_wdata[0], 32'hA5A5_A5A5);
            chk("t2_wdata1", ap_wdata[1], 32'h5A5A_5A5A);
            chk("t2_psel0", 32'(ap_sel[0]), 32'd2);
            chk("t2_psel1", 32'(ap_sel[1]), 32'd2);
            chk("t2_pwrite", 32'(ap_wr[1]), 32'd1);
        end
        chk("t2_ndone", 32'(dq_resp.size()), 32'd1);
        if (dq_resp.size() > 0) chk("t2_done_resp", 32'(dq_resp[0]), 32'd0);
        chk("t2_wq_empty", 32'(wq.size()), 32'd0);

        // 3: write INCR, error on beat 1 only
        clear_logs();
        err_addr = 32'h204;
        wq.push_back(32'h1111_1111); wq.push_back(32'h2222_2222); wq.push_back(32'h3333_3333);
        send_cmd(1'b1, 32'h200, 4'd2, 3'd2, 2'b01);
        wait_idle();
        err_addr = 32'hFFFF_FFFF;
        chk_apb("t3", 3, 32'h200, 32'h204, 32'h208, 32'h0);
        if (ap_wdata.size() == 3) chk("t3_wdata2", ap_wdata[2], 32'h3333_3333);
        chk("t3_ndone", 32'(dq_resp.size()), 32'd1);
        if (dq_resp.size() > 0) chk("t3_done_resp", 32'(dq_resp[0]), 32'd2);

        // 4: read WRAP, error on the wrapped beat
        clear_logs();
        err_addr = 32'h30;
        send_cmd(1'b0, 32'h38, 4'd3, 3'd2, 2'b10);
        wait_idle();
        err_addr = 32'hFFFF_FFFF;
        chk_apb("t4", 4, 32'h38, 32'h3C, 32'h30, 32'h34);
        chk_rd("t4", 4);
        if (rq_resp.size() == 4) begin
            chk("t4_resp1", 32'(rq_resp[1]), 32'd0);
            chk("t4_resp2", 32'(rq_resp[2]), 32'd2);
            chk("t4_resp3", 32'(rq_resp[3]), 32'd0);
        end

        // 4b: WRAP with len=2 behaves as INCR
        clear_logs();
        send_cmd(1'b0, 32'h38, 4'd2, 3'd2, 2'b10);
        wait_idle();
        chk_apb("t4b", 3, 32'h38, 32'h3C, 32'h40, 32'h0);

        // 5: wait states, read stalls, gapped write data
        clear_logs();
        stab_bad = 0;
        pready_dly = 5; rd_stall = 3;
        send_cmd(1'b0, 32'h40, 4'd1, 3'd2, 2'b01);
        wait_idle();
        chk_apb("t5r", 2, 32'h40, 32'h44, 32'h0, 32'h0);
        chk_rd("t5r", 2);
        clear_logs();
        wd_gap = 3;
        wq.push_back(32'hDEAD_0001); wq.push_back(32'hDEAD_0002);
        send_cmd(1'b1, 32'h80, 4'd1, 3'd2, 2'b01);
        wait_idle();
        chk_apb("t5w", 2, 32'h80, 32'h84, 32'h0, 32'h0);
        if (ap_wdata.size() == 2) begin
            chk("t5w_wdata0", ap_wdata[0], 32'hDEAD_0001);
            chk("t5w_wdata1", ap_wdata[1], 32'hDEAD_0002);
        end
        chk("t5w_ndone", 32'(dq_resp.size()), 32'd1);
        chk("t5_stable", 32'(stab_bad), 32'd0);
        wd_gap = 0; rd_stall = 0;

        // 6: reset during ACCESS of the third beat
        clear_logs();
        send_cmd(1'b0, 32'h300, 4'd3, 3'd2, 2'b01);
        begin
            int t;
            t = 0;
            while (!(penable_o && paddr_o == 32'h308) && t < 300) begin @(negedge clk); t++; end
            chk("t6_reach_access", 32'(penable_o && paddr_o == 32'h308), 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_psel", 32'(psel_o), 32'd0);
        chk("t6_rst_penable", 32'(penable_o), 32'd0);
        chk("t6_rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        pready_dly = 0;
        @(negedge clk);
        chk("t6_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("t6_rd_valid", 32'(rd_valid_o), 32'd0);
        clear_logs();
        send_cmd(1'b0, 32'h10, 4'd0, 3'd2, 2'b01);
        wait_idle();
        chk_apb("t6", 1, 32'h10, 32'h0, 32'h0, 32'h0);
        chk_rd("t6", 1);

        chk("protocol", 32'(proto_bad), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $fatal(1);
    end
endmodule
